// File: rtl/npu_inst_dispatcher.sv
// NPU instruction dispatcher: buffers instruction words in a small FIFO, decodes the
// head and issues in order to the compute, memory or vector class. Each class keeps a
// count of outstanding operations. OP_SYNC waits until every class has drained.
// Opcode field is inst[7:0]:
//   00 NOP, 01 CONV, 02 FC, 03 LOAD, 04 STORE, 05 ACT, 06 POOL, 07 ADD, 08 MUL,
//   09 CONCAT, 0A SPLIT, 0B SYNC; every other value is illegal.
// Optional macro DISPATCH_PERF_CNT_EN adds the issued and stall performance counters.
// Without it, perf_issued_o and perf_stall_o are tied to zero.
module npu_inst_dispatcher #(
  parameter int unsigned INST_WIDTH      = 64,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            inst_valid_i,
  input  logic [INST_WIDTH-1:0]           inst_data_i,
  output logic                            inst_ready_o,
  output logic [2:0]                      disp_valid_o,
  input  logic [2:0]                      disp_ready_i,
  output logic [INST_WIDTH-1:0]           disp_inst_o,
  input  logic [2:0]                      unit_done_i,
  output logic                            sync_done_o,
  output logic                            illegal_op_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
  output logic                            busy_o,
  output logic [31:0]                     perf_issued_o,
  output logic [31:0]                     perf_stall_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OsW  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_CONV   = 8'h01;
  localparam logic [7:0] OP_FC     = 8'h02;
  localparam logic [7:0] OP_LOAD   = 8'h03;
  localparam logic [7:0] OP_STORE  = 8'h04;
  localparam logic [7:0] OP_ACT    = 8'h05;
  localparam logic [7:0] OP_POOL   = 8'h06;
  localparam logic [7:0] OP_ADD    = 8'h07;
  localparam logic [7:0] OP_MUL    = 8'h08;
  localparam logic [7:0] OP_CONCAT = 8'h09;
  localparam logic [7:0] OP_SPLIT  = 8'h0A;
  localparam logic [7:0] OP_SYNC   = 8'h0B;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_SYNC  = 2'd2;

  // ---------------------------------------------------------------------------
  // Instruction FIFO
  // ---------------------------------------------------------------------------
  logic [INST_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  push, pop;
  logic                  fifo_empty;

  // Ready only reflects occupancy, so a full FIFO refuses a push even while popping.
  assign inst_ready_o = (count_q != CntW'(FIFO_DEPTH));
  assign push         = inst_valid_i & inst_ready_o & ~flush_i;
  assign fifo_empty   = (count_q == '0);
  assign fifo_count_o = count_q;

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= inst_data_i;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Head decode
  // ---------------------------------------------------------------------------
  logic [INST_WIDTH-1:0] head;
  logic [7:0]            head_op;
  logic [2:0]            head_cls;
  logic                  head_nop, head_sync, head_illegal;

  assign head    = mem_q[rd_ptr_q];
  assign head_op = head[7:0];

  // Map the head opcode to a one-hot class or to one of the special kinds.
  always_comb begin
    head_cls     = 3'b000;
    head_nop     = 1'b0;
    head_sync    = 1'b0;
    head_illegal = 1'b0;
    case (head_op)
      OP_CONV, OP_FC:                      head_cls = 3'b001;
      OP_LOAD, OP_STORE:                   head_cls = 3'b010;
      OP_ACT, OP_POOL, OP_ADD, OP_MUL,
      OP_CONCAT, OP_SPLIT:                 head_cls = 3'b100;
      OP_NOP:                              head_nop = 1'b1;
      OP_SYNC:                             head_sync = 1'b1;
      default:                             head_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outstanding-operation counters
  // ---------------------------------------------------------------------------
  logic [2:0][OsW-1:0] os_q, os_d;
  logic [2:0]          below_max;
  logic [2:0]          done_eff;
  logic [2:0]          hs_vec;
  logic                issue_hs;
  logic [2:0]          disp_valid_q, disp_valid_d;

  // A handshake that coincides with flush is discarded along with the issue register.
  assign hs_vec   = disp_valid_q & disp_ready_i & {3{~flush_i}};
  assign issue_hs = |hs_vec;

  // Completion on an empty counter is ignored so the count never underflows.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      below_max[c] = (os_q[c] < OsW'(MAX_OUTSTANDING));
      done_eff[c]  = unit_done_i[c] & (os_q[c] != '0);
    end
  end

  // Next counter value: issue and completion in the same cycle cancel.
  always_comb begin
    os_d = os_q;
    for (int c = 0; c < 3; c++) begin
      if (hs_vec[c] && !done_eff[c]) begin
        os_d[c] = os_q[c] + OsW'(1);
      end else if (!hs_vec[c] && done_eff[c]) begin
        os_d[c] = os_q[c] - OsW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic [INST_WIDTH-1:0] disp_inst_q, disp_inst_d;
  logic                  illegal_q, illegal_d;
  logic                  sync_done_q, sync_done_d;

  // Next-state logic; flush overrides every decision except the counters.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    disp_valid_d = disp_valid_q;
    disp_inst_d  = disp_inst_q;
    illegal_d    = illegal_q;
    sync_done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (head_nop) begin
            pop = 1'b1;
          end else if (head_illegal) begin
            pop       = 1'b1;
            illegal_d = 1'b1;
          end else if (head_sync) begin
            pop     = 1'b1;
            state_d = S_SYNC;
          end else if ((head_cls & below_max) != 3'b000) begin
            pop          = 1'b1;
            disp_valid_d = head_cls;
            disp_inst_d  = head;
            state_d      = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (issue_hs) begin
          disp_valid_d = 3'b000;
          state_d      = S_IDLE;
        end
      end
      S_SYNC: begin
        // Retire as soon as the counters reach zero after this cycle's completions.
        if (os_d == '0) begin
          sync_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d      = S_IDLE;
      pop          = 1'b0;
      disp_valid_d = 3'b000;
      illegal_d    = 1'b0;
      sync_done_d  = 1'b0;
    end
  end

  // State, issue register, flags and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      disp_valid_q <= 3'b000;
      disp_inst_q  <= '0;
      illegal_q    <= 1'b0;
      sync_done_q  <= 1'b0;
      os_q         <= '0;
    end else begin
      state_q      <= state_d;
      disp_valid_q <= disp_valid_d;
      disp_inst_q  <= disp_inst_d;
      illegal_q    <= illegal_d;
      sync_done_q  <= sync_done_d;
      os_q         <= os_d;
    end
  end

  assign disp_valid_o = disp_valid_q;
  assign disp_inst_o  = disp_inst_q;
  assign sync_done_o  = sync_done_q;
  assign illegal_op_o = illegal_q;
  assign busy_o       = ~fifo_empty | (state_q != S_IDLE) | (os_q != '0);

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_stall_q;
  logic        stall_cyc;

  // A stall is a waiting head with no pop, or an offered issue that is not accepted.
  assign stall_cyc = ~flush_i &
                     (((state_q == S_IDLE) & ~fifo_empty & ~pop) |
                      ((disp_valid_q != 3'b000) & ~issue_hs));

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (issue_hs && (perf_issued_q != '1)) perf_issued_q <= perf_issued_q + 32'd1;
      if (stall_cyc && (perf_stall_q != '1)) perf_stall_q  <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued_o = perf_issued_q;
  assign perf_stall_o  = perf_stall_q;
`else
  assign perf_issued_o = '0;
  assign perf_stall_o  = '0;
`endif

endmodule
